multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, meaning register count; AW = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter NUM_RD, default 2, meaning number of read ports.
REQ-004 The block SHALL have parameter NUM_WR, default 2, meaning number of write ports.
REQ-005 The block SHALL have parameter ZERO_REG_EN, default 1, meaning register 0 is hardwired to zero.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 The port list SHALL be:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD x AW  read addresses.
- rd_data  out  NUM_RD x DATA_W  read data.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR x AW  write addresses.
- wr_data  in  NUM_WR x DATA_W  write data.
- clr_req  in  1  request a full clear.
- busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when a clear completes.

Function
REQ-008 Reads SHALL be combinational (zero latency); rd_data[i] SHALL be 0 when rd_en[i]=0.
REQ-009 rd_data[i] SHALL be 0 when rd_addr[i] is 0 and ZERO_REG_EN=1, or when rd_addr[i] >= NUM_REGS.
REQ-010 Each enabled read SHALL return the same-cycle wr_data of the highest-index write port with wr_en=1 and a matching wr_addr (bypass); otherwise it SHALL return the stored value.
REQ-011 Writes SHALL commit on the rising clk edge when wr_en=1, busy=0, the address is < NUM_REGS, and the address is not 0 with ZERO_REG_EN=1.
REQ-012 When several ports write the same address in one cycle, the highest-index port SHALL win, both in storage and in the bypass.
REQ-013 The clear FSM SHALL have states IDLE and CLEAR, with a clear counter cnt of width AW.
REQ-014 On leaving reset the FSM SHALL be in CLEAR with cnt=0.
REQ-015 In CLEAR the block SHALL write register cnt to 0 each cycle and increment cnt.
REQ-016 In CLEAR with cnt=NUM_REGS-1, the FSM SHALL go to IDLE on the next edge, and clr_done SHALL be 1 for the first cycle in IDLE.
REQ-017 A full clear SHALL take exactly NUM_REGS cycles in CLEAR.
REQ-018 In IDLE, clr_req=1 SHALL move the FSM to CLEAR with cnt=0 on the next edge.
REQ-019 clr_req SHALL be ignored while in CLEAR (no restart); clr_req in the clr_done cycle SHALL start a new clear.
REQ-020 busy SHALL be 1 exactly when state=CLEAR.
REQ-021 While busy=1, all write ports SHALL be ignored, the bypass disabled, and all rd_data forced to 0.
REQ-022 A write and clr_req in the same IDLE cycle: the write SHALL commit, then the clear SHALL overwrite it.

Reset
REQ-023 rst=1 SHALL immediately force state=CLEAR, cnt=0, busy=1 and clr_done=0, and rd_data SHALL read 0.
REQ-024 Register storage SHALL NOT be reset directly; it SHALL be cleared only by the clear sequence, so it maps to RAM or flops.
REQ-025 Reset asserted mid-clear SHALL restart the clear from cnt=0.

Structure
REQ-026 Package rf_pkg SHALL hold the default DATA_W and NUM_REGS constants and the enum rf_state_t {RF_IDLE, RF_CLEAR}.
REQ-027 The FSM, counter, busy and clr_done SHALL live in sub-module rf_clear_seq; storage, write arbitration and bypass SHALL be in the top module.

Verification
REQ-028 The bench SHALL cover the scenarios below at default parameters.
- Reset release -> busy=1 for 32 cycles, clr_done pulses once, then all 32 reads return 0.
- wr0 addr 5 = 0xDEADBEEF, rd0 addr 5 in the same cycle -> rd_data0=0xDEADBEEF; the next cycle still returns it from storage.
- wr0 and wr1 both to addr 7 (0x11 and 0x22) -> rd returns 0x22 in the same and following cycles.
- Write 0xFFFFFFFF to addr 0 -> reads of addr 0 return 0; with ZERO_REG_EN=0 the read returns 0xFFFFFFFF.
- clr_req after loading regs 1..31 -> 32 busy cycles, writes during busy are dropped, a second clr_req mid-clear is ignored, and all regs read 0 afterwards.
- rst pulsed at cnt=10 -> clear restarts and busy lasts 32 cycles after rst falls.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and clear-sequencer state encoding for the multiport register file.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every register address once, writing zero, on reset or on request.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RF_CLEAR;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      clr_done <= done_nxt;
    end
  end

  // clr_req is only looked at in IDLE, so a request during a clear never restarts it
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      RF_CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = RF_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RF_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == RF_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file with combinational reads, same-cycle write bypass and a
// sequenced clear; storage has no reset so it can map onto RAM or plain flops.
module multiport_register_file
  import rf_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int NUM_REGS    = RF_NUM_REGS,
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 2,
  parameter int ZERO_REG_EN = 1,
  localparam int AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic                           clr_req,
  output logic                           busy,
  output logic                           clr_done
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [AW-1:0]     clr_addr;

  // An address is usable if it exists and is not the hardwired zero register
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NUM_REGS) && !((ZERO_REG_EN != 0) && (a == '0));
  endfunction

  rf_clear_seq #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_addr (clr_addr)
  );

  // Ports are visited in ascending order so the highest-index writer lands last
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_addr] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && addr_ok(wr_addr[j])) begin
          mem[wr_addr[j]] <= wr_data[j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i] = '0;
      if (rd_en[i] && !busy && addr_ok(rd_addr[i])) begin
        rd_data[i] = mem[rd_addr[i]];
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j] == rd_addr[i])) begin
            rd_data[i] = wr_data[j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: directed table, hand sequences and random traffic vs a model.
module tb_multiport_register_file;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0]            rd_en, wr_en;
  logic [1:0][AW-1:0]    rd_addr, wr_addr;
  logic [1:0][DW-1:0]    wr_data, rd_data_a, rd_data_b;
  logic                  clr_req;
  logic                  busy_a, busy_b, done_a, done_b;

  multiport_register_file dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .busy(busy_a), .clr_done(done_a)
  );

  multiport_register_file #(.ZERO_REG_EN(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req),
    .busy(busy_b), .clr_done(done_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: register contents plus the number of edges since the last clear began
  logic [DW-1:0] m_mem_a [NR];
  logic [DW-1:0] m_mem_b [NR];
  int            m_age;

  typedef struct {
    logic [1:0]    wen;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [1:0]    ren;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic [DW-1:0] eb0;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int zen, input int p);
    int a;
    logic [DW-1:0] v;
    if (!rd_en[p] || m_age < NR) return '0;
    a = int'(rd_addr[p]);
    if (zen != 0 && a == 0) return '0;
    v = (zen != 0) ? m_mem_a[a] : m_mem_b[a];
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && int'(wr_addr[j]) == a) v = wr_data[j];
    return v;
  endfunction

  task automatic check_model();
    for (int p = 0; p < 2; p++) begin
      chk("model_rd_a", rd_data_a[p], m_read(1, p));
      chk("model_rd_b", rd_data_b[p], m_read(0, p));
    end
    chk("model_busy_a", busy_a, m_age < NR);
    chk("model_busy_b", busy_b, m_age < NR);
    chk("model_done_a", done_a, m_age == NR);
    chk("model_done_b", done_b, m_age == NR);
  endtask

  task automatic model_edge();
    int a;
    if (rst) begin
      m_age = 0;
      return;
    end
    if (m_age < NR) begin
      m_mem_a[m_age] = '0;
      m_mem_b[m_age] = '0;
      m_age++;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j]) begin
          a = int'(wr_addr[j]);
          if (a != 0) m_mem_a[a] = wr_data[j];
          m_mem_b[a] = wr_data[j];
        end
      end
      if (clr_req) m_age = 0;
      else if (m_age < 1000) m_age++;
    end
  endtask

  task automatic settle_check();
    #1;
    check_model();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic tick();
    settle_check();
    edge_step();
  endtask

  task automatic rand_inputs();
    for (int j = 0; j < 2; j++) begin
      wr_addr[j] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      rd_addr[j] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wr_data[j] = $urandom;
    end
    wr_en = 2'($urandom);
    rd_en = 2'($urandom);
  endtask

  // Counts busy cycles until the clear finishes; noisy mode fires traffic and a stray clr_req
  task automatic wait_clear(input bit noisy);
    int n = 0;
    for (int k = 0; k < 40; k++) begin
      if (noisy) begin
        rand_inputs();
        clr_req = (n == 10);
      end
      settle_check();
      if (!busy_a) break;
      n++;
      edge_step();
    end
    chk("busy_cycles", n, 32);
    chk("clr_done_pulse", done_a, 1'b1);
    wr_en = '0;
    clr_req = 1'b0;
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < NR; a++) begin
      wr_en = '0;
      rd_en = 2'b11;
      rd_addr[0] = AW'(a);
      rd_addr[1] = AW'(NR - 1 - a);
      settle_check();
      chk("cleared_rd_a", rd_data_a[0], '0);
      chk("cleared_rd_b", rd_data_b[0], '0);
      edge_step();
    end
    rd_en = '0;
  endtask

  initial begin
    tbl[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b11, 5'd5, 5'd6, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    tbl[1] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    tbl[2] = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 2'b11, 5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 32'h22};
    tbl[3] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd5, 32'h22, 32'h0, 32'h22};
    tbl[4] = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF};
    tbl[5] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd7, 32'h0, 32'h22, 32'hFFFFFFFF};
    tbl[6] = '{2'b11, 5'd3, 32'h1234, 5'd3, 32'hA5A5, 2'b11, 5'd3, 5'd3, 32'hA5A5, 32'hA5A5, 32'hA5A5};
    tbl[7] = '{2'b10, 5'd0, 32'h0, 5'd9, 32'hCAFEF00D, 2'b11, 5'd3, 5'd9, 32'hA5A5, 32'hCAFEF00D, 32'hA5A5};

    for (int a = 0; a < NR; a++) begin
      m_mem_a[a] = '0;
      m_mem_b[a] = '0;
    end
    m_age = 0;
    rst = 1'b1;
    rd_en = 2'b11; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    @(negedge clk);
    tick();
    settle_check();
    chk("reset_busy", busy_a, 1'b1);
    chk("reset_done", done_a, 1'b0);
    chk("reset_rd", rd_data_a[0], '0);
    edge_step();

    // Reset release: full clear, then every register reads zero
    rst = 1'b0;
    rd_en = '0;
    wait_clear(1'b0);
    read_all_zero();

    for (int v = 0; v < 8; v++) begin
      wr_en = tbl[v].wen;
      wr_addr[0] = tbl[v].wa0; wr_data[0] = tbl[v].wd0;
      wr_addr[1] = tbl[v].wa1; wr_data[1] = tbl[v].wd1;
      rd_en = tbl[v].ren;
      rd_addr[0] = tbl[v].ra0; rd_addr[1] = tbl[v].ra1;
      settle_check();
      chk($sformatf("tbl%0d_rd0", v), rd_data_a[0], tbl[v].e0);
      chk($sformatf("tbl%0d_rd1", v), rd_data_a[1], tbl[v].e1);
      chk($sformatf("tbl%0d_rdb0", v), rd_data_b[0], tbl[v].eb0);
      edge_step();
    end

    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      clr_req = ($urandom_range(0, 49) == 0);
      tick();
    end
    wr_en = '0; clr_req = 1'b0;
    for (int c = 0; c < 40; c++) tick();

    // Load 1..31, then a write in the same cycle as clr_req must still end up cleared
    for (int a = 1; a < NR; a++) begin
      wr_en = 2'b01; wr_addr[0] = AW'(a); wr_data[0] = $urandom | 32'h1;
      tick();
    end
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h99; clr_req = 1'b1;
    tick();
    wr_en = '0; clr_req = 1'b0;
    wait_clear(1'b1);
    read_all_zero();

    // Reset mid-clear at cnt=10 restarts the whole sequence
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1;
    m_age = 0;
    settle_check();
    chk("midclear_rst_busy", busy_a, 1'b1);
    chk("midclear_rst_done", done_a, 1'b0);
    edge_step();
    edge_step();
    rst = 1'b0;
    wait_clear(1'b0);

    // clr_req during the clr_done cycle starts another clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    settle_check();
    chk("restart_on_done", busy_a, 1'b1);
    wait_clear(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
